// File: rtl/snow64_icache_fill_responder_pkg.sv
// Shared types for the instruction-cache line-fill responder: FSM state,
// beat geometry helpers and the partial-port structs for cache and memory sides.
package PkgSnow64InstrCache;

    localparam int unsigned ADDR_WIDTH__ICACHE_FILL = 64;
    localparam int unsigned LINE_WIDTH__ICACHE_FILL = 256;
    localparam int unsigned BEAT_WIDTH__ICACHE_FILL = 64;

    localparam int unsigned MSB_POS__LINE_DATA = LINE_WIDTH__ICACHE_FILL - 1;
    localparam int unsigned NUM_BEATS__ICACHE_FILL =
        LINE_WIDTH__ICACHE_FILL / BEAT_WIDTH__ICACHE_FILL;
    localparam int unsigned BEAT_OFFSET__ICACHE_FILL = BEAT_WIDTH__ICACHE_FILL / 8;
    localparam int unsigned LINE_OFFSET__ICACHE_FILL = LINE_WIDTH__ICACHE_FILL / 8;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_ISSUE,
        FILL_WAIT,
        FILL_DELIVER
    } IcacheFillState;

    function automatic int unsigned num_beats(input int unsigned line_w,
                                              input int unsigned beat_w);
        return line_w / beat_w;
    endfunction

    function automatic int unsigned beat_bytes(input int unsigned beat_w);
        return beat_w / 8;
    endfunction

    function automatic int unsigned line_bytes(input int unsigned line_w);
        return line_w / 8;
    endfunction

    typedef struct packed {
        logic                               req;
        logic [ADDR_WIDTH__ICACHE_FILL-1:0] addr;
    } PartialPortIn_InstrCache_FillReq;

    typedef struct packed {
        logic                               valid;
        logic [LINE_WIDTH__ICACHE_FILL-1:0] data;
        logic                               busy;
    } PartialPortOut_InstrCache_FillResp;

    typedef struct packed {
        logic                               req;
        logic [ADDR_WIDTH__ICACHE_FILL-1:0] addr;
    } PartialPortOut_InstrCache_MemAccess;

    typedef struct packed {
        logic                               gnt;
        logic                               rdata_valid;
        logic [BEAT_WIDTH__ICACHE_FILL-1:0] rdata;
    } PartialPortIn_InstrCache_MemAccess;

endpackage

// File: rtl/snow64_icache_fill_responder.sv
// Memory-side line-fill responder for the instruction cache: fetches one line as
// in-order single-outstanding beats and returns it with a one-cycle valid pulse.
module snow64_icache_fill_responder
    import PkgSnow64InstrCache::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cache_req,
    input  logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_valid,
    output logic [LINE_WIDTH-1:0] cache_data,
    output logic                  busy,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rdata_valid,
    input  logic [BEAT_WIDTH-1:0] mem_rdata
);

    localparam int unsigned NUM_BEATS  = num_beats(LINE_WIDTH, BEAT_WIDTH);
    localparam int unsigned BEAT_BYTES = beat_bytes(BEAT_WIDTH);
    localparam int unsigned LINE_BYTES = line_bytes(LINE_WIDTH);
    localparam int unsigned CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(NUM_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LINE_OFFSET = ADDR_WIDTH'(LINE_BYTES - 1);

    IcacheFillState                       state_q;
    logic [CNT_W-1:0]                     beat_cnt_q;
    logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] line_q;
    logic                                 cache_valid_q;
    logic                                 mem_req_q;
    logic [ADDR_WIDTH-1:0]                mem_addr_q;

    logic [ADDR_WIDTH-1:0] line_base_d;
    logic [ADDR_WIDTH-1:0] beat_addr_d;

    assign line_base_d = cache_addr & ~LINE_OFFSET;
    // Base is line-aligned, so stepping by one beat never carries out of the line.
    assign beat_addr_d = mem_addr_q + BEAT_STRIDE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL_IDLE;
            beat_cnt_q    <= '0;
            line_q        <= '0;
            cache_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            case (state_q)
                FILL_IDLE: begin
                    cache_valid_q <= 1'b0;
                    if (cache_req) begin
                        mem_addr_q <= line_base_d;
                        beat_cnt_q <= '0;
                        mem_req_q  <= 1'b1;
                        state_q    <= FILL_ISSUE;
                    end
                end
                FILL_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (mem_rdata_valid) begin
                        line_q[beat_cnt_q] <= mem_rdata;
                        if (beat_cnt_q == LAST_BEAT) begin
                            cache_valid_q <= 1'b1;
                            state_q       <= FILL_DELIVER;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                            mem_addr_q <= beat_addr_d;
                            mem_req_q  <= 1'b1;
                            state_q    <= FILL_ISSUE;
                        end
                    end
                end
                FILL_DELIVER: begin
                    cache_valid_q <= 1'b0;
                    state_q       <= FILL_IDLE;
                end
                default: begin
                    cache_valid_q <= 1'b0;
                    mem_req_q     <= 1'b0;
                    state_q       <= FILL_IDLE;
                end
            endcase
        end
    end

    assign cache_valid = cache_valid_q;
    assign cache_data  = line_q;
    assign busy        = (state_q != FILL_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule
